// File: rtl/sparse_mul_pkg.sv
// sparse_mul_pkg: shared sizes and FSM states for the sparse_mul_256_16 host sequencer.
package sparse_mul_pkg;
  localparam int N = 512;
  localparam int H = 256;
  localparam int CORE_NUM = 2;
  localparam int COEFF_WIDTH = 8;
  localparam int POS_WIDTH = $clog2(N);
  localparam int POS_RAM_DEPTH = (H + CORE_NUM - 1) / CORE_NUM;
  localparam int POS_RAM_WIDTH = (POS_WIDTH + 1) * CORE_NUM;
  localparam int RES_LEN = N / 2;
  localparam int POS_AW = $clog2(POS_RAM_DEPTH);
  localparam int RES_AW = $clog2(RES_LEN);
  localparam int RCNT_W = RES_AW + 1;
  typedef enum logic [2:0] {IDLE, LOAD_POLY, LOAD_POS, START, WAIT_DONE, READ, DRAIN} state_t;
endpackage

// File: rtl/sparse_mul_host_ctrl_res_skid_fifo.sv
// res_skid_fifo: 2-entry result FIFO absorbing read data that returns one cycle after issue.
module res_skid_fifo import sparse_mul_pkg::*; (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [COEFF_WIDTH-1:0] din,
  output logic [COEFF_WIDTH-1:0] dout,
  output logic [1:0]             count
);
  logic [COEFF_WIDTH-1:0] mem [2];
  logic wp, rp;
  assign dout = mem[rp];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp <= 1'b0;
      rp <= 1'b0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp <= ~wp;
      end
      if (pop) rp <= ~rp;
      count <= count + 2'(push) - 2'(pop);
    end
endmodule

// File: rtl/sparse_mul_host_ctrl.sv
// sparse_mul_host_ctrl: loads the multiplier RAMs from two streams, runs it, and streams results out.
// Define SPARSE_MUL_CYCLE_CNT_EN to add the compute_cycles port.
module sparse_mul_host_ctrl import sparse_mul_pkg::*; (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_start,
  output logic                     busy,
  output logic                     job_done,
  input  logic                     poly_valid,
  output logic                     poly_ready,
  input  logic [COEFF_WIDTH-1:0]   poly_data,
  input  logic                     pos_valid,
  output logic                     pos_ready,
  input  logic [POS_RAM_WIDTH-1:0] pos_data,
  output logic                     mem_poly_wren,
  output logic [POS_WIDTH-1:0]     mem_poly_wr_addr,
  output logic [COEFF_WIDTH-1:0]   mem_poly_din,
  output logic                     mem_pos_wren,
  output logic [POS_AW-1:0]        mem_pos_wr_addr,
  output logic [POS_RAM_WIDTH-1:0] mem_pos_din,
  output logic                     mul_start,
  input  logic                     mul_done,
  output logic                     res_rden,
  output logic [RES_AW-1:0]        res_rd_addr,
  input  logic [COEFF_WIDTH-1:0]   res_rdata,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [COEFF_WIDTH-1:0]   res_data
`ifdef SPARSE_MUL_CYCLE_CNT_EN
  ,
  output logic [31:0]              compute_cycles
`endif
);
  state_t state, state_n;
  logic [POS_WIDTH-1:0] cnt;
  logic [RCNT_W-1:0] rcnt;
  logic [1:0] fcount;
  logic inflight, pop, last_poly, last_pos;
  assign busy = state != IDLE;
  assign poly_ready = state == LOAD_POLY;
  assign pos_ready = state == LOAD_POS;
  assign mem_poly_wren = poly_ready & poly_valid;
  assign mem_pos_wren = pos_ready & pos_valid;
  assign mem_poly_wr_addr = cnt;
  assign mem_pos_wr_addr = cnt[POS_AW-1:0];
  assign mem_poly_din = mem_poly_wren ? poly_data : '0;
  assign mem_pos_din = mem_pos_wren ? pos_data : '0;
  assign last_poly = mem_poly_wren && int'(cnt) == N - 1;
  assign last_pos = mem_pos_wren && int'(cnt) == POS_RAM_DEPTH - 1;
  assign mul_start = state == START;
  assign res_valid = fcount != 2'd0;
  assign pop = res_valid & res_ready;
  // Occupancy after this cycle's pop must leave room for the new read's data.
  assign res_rden = state == READ && int'(rcnt) < RES_LEN &&
                    int'(fcount) + int'(inflight) - int'(pop) < 2;
  assign res_rd_addr = rcnt[RES_AW-1:0];
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      state_n = cmd_start ? LOAD_POLY : IDLE;
      LOAD_POLY: state_n = last_poly ? LOAD_POS : LOAD_POLY;
      LOAD_POS:  state_n = last_pos ? START : LOAD_POS;
      START:     state_n = WAIT_DONE;
      WAIT_DONE: state_n = mul_done ? READ : WAIT_DONE;
      READ:      state_n = (res_rden && int'(rcnt) == RES_LEN - 1) ? DRAIN : READ;
      DRAIN:     state_n = (fcount == 2'd0 && !inflight) ? IDLE : DRAIN;
      default:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      rcnt <= '0;
      inflight <= 1'b0;
      job_done <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= (state == IDLE || last_poly || last_pos) ? '0 : cnt + POS_WIDTH'(mem_poly_wren | mem_pos_wren);
      rcnt <= state == IDLE ? '0 : rcnt + RCNT_W'(res_rden);
      inflight <= res_rden;
      job_done <= state == DRAIN && state_n == IDLE;
    end
  res_skid_fifo u_fifo (
    .clk(clk),
    .rst(rst),
    .push(inflight),
    .pop(pop),
    .din(res_rdata),
    .dout(res_data),
    .count(fcount)
  );
`ifdef SPARSE_MUL_CYCLE_CNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) compute_cycles <= '0;
    else if (state == START) compute_cycles <= '0;
    else if (state == WAIT_DONE && !(&compute_cycles)) compute_cycles <= compute_cycles + 32'd1;
`endif
endmodule

// File: tb/tb_sparse_mul_host_ctrl.sv
// tb_sparse_mul_host_ctrl: table-driven job runs plus reset and idle corner sequences.
module tb_sparse_mul_host_ctrl;
  import sparse_mul_pkg::*;
  logic clk = 0, rst = 1, cmd_start = 0, busy, job_done;
  logic poly_valid = 0, poly_ready, pos_valid = 0, pos_ready;
  logic [COEFF_WIDTH-1:0] poly_data = '0, mem_poly_din, res_rdata, res_data;
  logic [POS_RAM_WIDTH-1:0] pos_data = '0, mem_pos_din;
  logic mem_poly_wren, mem_pos_wren, mul_start, mul_done = 0, res_rden, res_valid, res_ready = 0;
  logic [POS_WIDTH-1:0] mem_poly_wr_addr;
  logic [POS_AW-1:0] mem_pos_wr_addr;
  logic [RES_AW-1:0] res_rd_addr;
`ifdef SPARSE_MUL_CYCLE_CNT_EN
  logic [31:0] compute_cycles;
`endif
  logic [COEFF_WIDTH-1:0] res_ram [RES_LEN];
  int checks = 0, errors = 0;
  int poly_n, poly_bad, pos_n, pos_bad, start_n, order_bad, rd_bad, issued, beat_n, beat_bad, max_out, done_n;
  bit busy_at_done, extra_done, timeout, job_over;

  typedef struct {
    bit gaps;
    bit bp;
    int delay;
    bit cmd_wait;
    int rst_at;
    int exp_polys;
    int exp_pos;
    int exp_beats;
  } vec_t;
  vec_t vecs [3];

  sparse_mul_host_ctrl dut (
    .clk(clk), .rst(rst), .cmd_start(cmd_start), .busy(busy), .job_done(job_done),
    .poly_valid(poly_valid), .poly_ready(poly_ready), .poly_data(poly_data),
    .pos_valid(pos_valid), .pos_ready(pos_ready), .pos_data(pos_data),
    .mem_poly_wren(mem_poly_wren), .mem_poly_wr_addr(mem_poly_wr_addr), .mem_poly_din(mem_poly_din),
    .mem_pos_wren(mem_pos_wren), .mem_pos_wr_addr(mem_pos_wr_addr), .mem_pos_din(mem_pos_din),
    .mul_start(mul_start), .mul_done(mul_done),
    .res_rden(res_rden), .res_rd_addr(res_rd_addr), .res_rdata(res_rdata),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
`ifdef SPARSE_MUL_CYCLE_CNT_EN
    , .compute_cycles(compute_cycles)
`endif
  );

  always #5 clk = ~clk;

  // Result RAM of the multiplier: data valid one cycle after the read request.
  always @(posedge clk) if (res_rden) res_rdata <= res_ram[res_rd_addr];

  function automatic int ones_out();
    return $countones({busy, job_done, poly_ready, pos_ready, mem_poly_wren, mem_poly_wr_addr, mem_poly_din,
                       mem_pos_wren, mem_pos_wr_addr, mem_pos_din, mul_start, res_rden, res_rd_addr,
                       res_valid, res_data});
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic poly_src(input bit gaps);
    int i = 0;
    while (i < N && !job_over) begin
      poly_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      poly_data = 8'(i % 251);
      @(negedge clk);
      if (poly_valid && poly_ready) i++;
      @(posedge clk); #1;
    end
    poly_valid = 0;
  endtask

  task automatic pos_src(input bit gaps);
    int i = 0;
    while (i < POS_RAM_DEPTH && !job_over) begin
      pos_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      pos_data = {10'(2 * i + 2), 10'(2 * i + 1)};
      @(negedge clk);
      if (pos_valid && pos_ready) i++;
      @(posedge clk); #1;
    end
    pos_valid = 0;
  endtask

  task automatic sink(input bit bp);
    int c = 0;
    while (!job_over) begin
      res_ready = bp ? (c % 4 == 0 || c % 4 == 3) : 1'b1;
      @(posedge clk); #1;
      c++;
    end
    res_ready = 0;
  endtask

  task automatic mul_model(input int d, input bit cmdw);
    bit seen = 0;
    while (!seen && !job_over) begin
      @(negedge clk);
      seen = mul_start;
    end
    if (seen) begin
      for (int k = 1; k <= d; k++) begin
        @(posedge clk); #1;
        cmd_start = cmdw && k == 3;
        mul_done = k == d;
      end
      @(posedge clk); #1;
      mul_done = 0;
      cmd_start = 0;
    end
  endtask

  task automatic mon(input int budget);
    int c = 0;
    poly_n = 0; poly_bad = 0; pos_n = 0; pos_bad = 0; start_n = 0; order_bad = 0; rd_bad = 0;
    issued = 0; beat_n = 0; beat_bad = 0; max_out = 0; done_n = 0; extra_done = 0; timeout = 1;
    while (c < budget && timeout) begin
      @(negedge clk);
      c++;
      if (mem_poly_wren) begin
        if (mem_poly_wr_addr != 9'(poly_n) || mem_poly_din != 8'(poly_n % 251)) poly_bad++;
        if (pos_n != 0 || start_n != 0) order_bad++;
        poly_n++;
      end
      if (mem_pos_wren) begin
        if (mem_pos_wr_addr != 7'(pos_n) || mem_pos_din != {10'(2 * pos_n + 2), 10'(2 * pos_n + 1)}) pos_bad++;
        if (poly_n != N || start_n != 0) order_bad++;
        pos_n++;
      end
      if (mul_start) begin
        start_n++;
        if (poly_n != N || pos_n != POS_RAM_DEPTH) order_bad++;
      end
      if (res_rden) begin
        if (res_rd_addr != 8'(issued) || start_n != 1) rd_bad++;
        issued++;
      end
      if (res_valid && res_ready) begin
        if (beat_n >= RES_LEN || res_data != res_ram[beat_n]) beat_bad++;
        beat_n++;
      end
      if (issued - beat_n > max_out) max_out = issued - beat_n;
      if (job_done) begin
        done_n++;
        busy_at_done = busy;
        timeout = 0;
      end
    end
    if (!timeout) begin
      @(negedge clk);
      extra_done = job_done;
    end
    job_over = 1;
  endtask

  task automatic run_job(input vec_t v, input int j);
    for (int i = 0; i < RES_LEN; i++) res_ram[i] = 8'(i * 37 + j * 11 + 5);
    job_over = 0;
    @(posedge clk); #1 cmd_start = 1;
    @(posedge clk); #1 cmd_start = 0;
    fork
      poly_src(v.gaps);
      pos_src(v.gaps);
      sink(v.bp);
      mul_model(v.delay, v.cmd_wait);
      mon(6000);
    join
  endtask

  task automatic reset_at_poly(input int idx);
    @(posedge clk); #1 cmd_start = 1;
    @(posedge clk); #1 cmd_start = 0;
    poly_valid = 1;
    for (int i = 0; i < idx; i++) begin
      poly_data = 8'(i % 251);
      @(posedge clk); #1;
    end
    poly_data = 8'(idx % 251);
    @(negedge clk);
    check("rst_pre_addr", int'(mem_poly_wr_addr), idx);
    check("rst_pre_wren", int'(mem_poly_wren), 1);
    #2 rst = 1;
    #1 check("rst_outputs_zero", ones_out(), 0);
    poly_valid = 0;
    @(posedge clk); #1 rst = 0;
    check("rst_after_busy", int'(busy), 0);
  endtask

  initial begin
    vecs[0] = '{gaps: 0, bp: 0, delay: 20, cmd_wait: 0, rst_at: 0, exp_polys: 512, exp_pos: 128, exp_beats: 256};
    vecs[1] = '{gaps: 1, bp: 1, delay: 10, cmd_wait: 1, rst_at: 0, exp_polys: 512, exp_pos: 128, exp_beats: 256};
    vecs[2] = '{gaps: 0, bp: 0, delay: 1000, cmd_wait: 0, rst_at: 300, exp_polys: 512, exp_pos: 128, exp_beats: 256};
    repeat (2) @(posedge clk);
    #1 check("reset_outputs_zero", ones_out(), 0);
    rst = 0;
    @(posedge clk); #1;
    mul_done = 1;
    @(posedge clk); #1 mul_done = 0;
    @(negedge clk);
    check("idle_ignores_done", int'({busy, mul_start, res_rden, res_valid}), 0);
    for (int j = 0; j < 3; j++) begin
      if (vecs[j].rst_at != 0) reset_at_poly(vecs[j].rst_at);
      run_job(vecs[j], j);
      check($sformatf("job%0d_timeout", j), int'(timeout), 0);
      check($sformatf("job%0d_poly_writes", j), poly_n, vecs[j].exp_polys);
      check($sformatf("job%0d_poly_addr_data", j), poly_bad, 0);
      check($sformatf("job%0d_pos_writes", j), pos_n, vecs[j].exp_pos);
      check($sformatf("job%0d_pos_addr_data", j), pos_bad, 0);
      check($sformatf("job%0d_mul_starts", j), start_n, 1);
      check($sformatf("job%0d_order", j), order_bad, 0);
      check($sformatf("job%0d_rd_addr", j), rd_bad, 0);
      check($sformatf("job%0d_reads", j), issued, vecs[j].exp_beats);
      check($sformatf("job%0d_beats", j), beat_n, vecs[j].exp_beats);
      check($sformatf("job%0d_beat_data", j), beat_bad, 0);
      check($sformatf("job%0d_outstanding_le2", j), int'(max_out <= 2), 1);
      check($sformatf("job%0d_done_pulses", j), done_n, 1);
      check($sformatf("job%0d_busy_at_done", j), int'(busy_at_done), 0);
      check($sformatf("job%0d_done_one_cycle", j), int'(extra_done), 0);
`ifdef SPARSE_MUL_CYCLE_CNT_EN
      check($sformatf("job%0d_compute_cycles", j), int'(compute_cycles), vecs[j].delay);
`endif
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
